vadd_arbiter: RTL and testbench
===============================

Name: vadd_arbiter

Overview:
- Round-robin arbiter that shares one pipelined 4-lane DSP vector-add datapath between two requesters.
- Issues at most one operand pair per cycle into the shared pipeline.
- Tracks each in-flight operation with a tag shift register matched to the pipeline latency, and steers each result back to the requester that issued it.
- Sits between two compute clients and the DSP vector-add instance.

Parameters:
- WIDTH, 8, lane width in bits.
- LANES, 4, number of lanes; vectors are packed with lane i at bits [i*WIDTH +: WIDTH].
- LATENCY, 2, cycles from operands presented with dsp_en=1 to the matching dsp_y; must be >= 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_a  in  LANES*WIDTH  requester 0 operand a.
- req0_b  in  LANES*WIDTH  requester 0 operand b.
- req1_valid, req1_ready, req1_a, req1_b  same as above, for requester 1.
- dsp_en  out  1  pipeline enable to the shared datapath.
- dsp_a  out  LANES*WIDTH  operand a to the datapath.
- dsp_b  out  LANES*WIDTH  operand b to the datapath.
- dsp_y  in  LANES*WIDTH  datapath result.
- rsp0_valid  out  1  result for requester 0 valid this cycle.
- rsp0_y  out  LANES*WIDTH  result data for requester 0.
- rsp1_valid, rsp1_y  same as above, for requester 1.
- outst0  out  $clog2(LATENCY+1)  operations in flight for requester 0.
- outst1  out  $clog2(LATENCY+1)  operations in flight for requester 1.

Behaviour:
- Reset: synchronous, active-high. All of the following are 0 during and after reset:
  - req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  - outst0, outst1;
  - priority pointer (requester 0 favoured first);
  - all tag stages.
- dsp_en is 0 while reset is high and 1 otherwise; the datapath is never stalled.
- Grant (combinational, same cycle):
  - Only one requester valid: it is granted.
  - Both valid: the requester named by the priority pointer is granted.
  - Neither valid: no grant.
  - reqN_ready = grant to N. A transfer happens when reqN_valid and reqN_ready are both high.
  - Ready is never asserted without the matching valid.
- Pointer update (registered): after a grant, the pointer moves to the other requester. With no grant it holds.
- Operand mux:
  - dsp_a/dsp_b carry the granted requester's operands.
  - With no grant they carry zeros.
- Tag pipeline:
  - LATENCY stages, each holding {valid, id}. Stage 0 loads {grant_any, grant_id} each cycle; the other stages shift by one.
  - When the last stage is valid, rspN_valid=1 for its id, and rspN_y = dsp_y in that same cycle (combinational pass-through, no extra register).
  - When the last stage is not valid, both rsp_valid are 0, whatever dsp_y shows.
- Total latency: operand accept at edge k gives the response visible in cycle k+LATENCY.
- Throughput: one operation per cycle. Under continuous dual requests the grants alternate 0,1,0,1,...
- Outstanding counters:
  - outstN increments on an issue to N and decrements on a response to N.
  - Issue and response in the same cycle: the counter holds.
  - The value never exceeds LATENCY.
- Arithmetic: the arbiter does not modify data. The expected result per lane is (a+b) mod 2^WIDTH, a two's-complement wrap.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is raised for operations issued before reset, even though dsp_y still drains.
- Inputs changing while ready is low are ignored. Requesters are not required to hold their operands.

Test Plan:
- Single op: req0 a={0,3,2,1}, b={-2,2,4,8} (lanes 0..3), one cycle -> rsp0_valid exactly LATENCY cycles later with y={-2,5,6,9}; rsp1_valid stays 0; outst0 goes 1 then 0.
- Contention: req0 and req1 held valid for 6 cycles, each with distinct operands -> grants 0,1,0,1,0,1; responses arrive in the same order on the matching rsp port with correct sums; outst0 and outst1 each peak at 1 when LATENCY=2.
- Overflow wrap: a lane with 127+1 -> -128; a lane with -128+(-1) -> 127; other lanes unaffected.
- Idle gaps: req1 only, valid on cycles 0,2,5 -> ready on exactly those cycles; rsp1_valid on cycles 0+L, 2+L and 5+L; no spurious responses in between.
- Reset mid-flight: issue 2 ops, assert reset for 1 cycle before their responses -> no rsp_valid for them; outst=0; pointer favours requester 0; the next op completes normally.
- Pointer fairness: req0 alone for 3 cycles, then both -> the first contended grant goes to req1, since the pointer moved after the last req0 grant.

Source files
------------

// File: rtl/vadd_arbiter.sv
// Round-robin arbiter sharing one pipelined LANES-wide vector-add datapath between two requesters.
// A tag shift register matched to LATENCY steers each dsp_y result back to the requester that issued it.
module vadd_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int LATENCY = 2,
    localparam int VW     = LANES * WIDTH,
    localparam int CW     = $clog2(LATENCY + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [VW-1:0] req0_a,
    input  logic [VW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [VW-1:0] req1_a,
    input  logic [VW-1:0] req1_b,
    output logic          dsp_en,
    output logic [VW-1:0] dsp_a,
    output logic [VW-1:0] dsp_b,
    input  logic [VW-1:0] dsp_y,
    output logic          rsp0_valid,
    output logic [VW-1:0] rsp0_y,
    output logic          rsp1_valid,
    output logic [VW-1:0] rsp1_y,
    output logic [CW-1:0] outst0,
    output logic [CW-1:0] outst1
);

    // Handshake: a transfer occurs in a cycle where reqN_valid && reqN_ready; ready is a
    // same-cycle grant that never rises without valid, and there is no response backpressure.
    logic                ptr;
    logic                grant0, grant1, grant_any;
    logic [LATENCY-1:0]  tag_v, tag_id;
    logic [CW-1:0]       cnt0, cnt1, cnt0_next, cnt1_next;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = req0_valid && (!req1_valid || !ptr);
            grant1 = req1_valid && (!req0_valid || ptr);
        end
    end

    assign grant_any  = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign dsp_en     = !reset;

    always_comb begin
        dsp_a = '0;
        dsp_b = '0;
        if (grant0) begin
            dsp_a = req0_a;
            dsp_b = req0_b;
        end else if (grant1) begin
            dsp_a = req1_a;
            dsp_b = req1_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant_any) begin
            ptr <= grant0;
        end
    end

    // Stage 0 captures this cycle's issue; the last stage lines up with dsp_y.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign rsp0_valid = !reset && tag_v[LATENCY-1] && !tag_id[LATENCY-1];
    assign rsp1_valid = !reset && tag_v[LATENCY-1] &&  tag_id[LATENCY-1];
    assign rsp0_y     = dsp_y;
    assign rsp1_y     = dsp_y;

    always_comb begin
        cnt0_next = cnt0;
        cnt1_next = cnt1;
        case ({grant0, rsp0_valid})
            2'b10:   cnt0_next = cnt0 + CW'(1);
            2'b01:   cnt0_next = cnt0 - CW'(1);
            default: cnt0_next = cnt0;
        endcase
        case ({grant1, rsp1_valid})
            2'b10:   cnt1_next = cnt1 + CW'(1);
            2'b01:   cnt1_next = cnt1 - CW'(1);
            default: cnt1_next = cnt1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0_next;
            cnt1 <= cnt1_next;
        end
    end

    assign outst0 = reset ? '0 : cnt0;
    assign outst1 = reset ? '0 : cnt1;

endmodule

// File: tb/tb_vadd_arbiter.sv
// Directed bench for vadd_arbiter: a behavioural LATENCY-deep vector adder stands in for the DSP,
// and every expected value below is hand-computed.
module tb_vadd_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int VW  = W * N;
    localparam int CW  = $clog2(LAT + 1);

    logic          clock;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [VW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          dsp_en;
    logic [VW-1:0] dsp_a, dsp_b, dsp_y;
    logic          rsp0_valid, rsp1_valid;
    logic [VW-1:0] rsp0_y, rsp1_y;
    logic [CW-1:0] outst0, outst1;

    int checks   = 0;
    int failures = 0;

    vadd_arbiter #(.WIDTH(W), .LANES(N), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dsp_en(dsp_en), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_y(dsp_y),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y),
        .outst0(outst0), .outst1(outst1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stand-in for the shared DSP: per-lane wrapping add, LAT register stages, advances when enabled.
    logic [VW-1:0] dsp_pipe [LAT];
    always @(posedge clock) begin
        if (dsp_en) begin
            for (int l = 0; l < N; l++) dsp_pipe[0][l*W +: W] <= dsp_a[l*W +: W] + dsp_b[l*W +: W];
            for (int s = 1; s < LAT; s++) dsp_pipe[s] <= dsp_pipe[s-1];
        end
    end
    assign dsp_y = dsp_pipe[LAT-1];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [VW-1:0] a0, input logic [VW-1:0] b0,
                         input logic v1, input logic [VW-1:0] a1, input logic [VW-1:0] b1);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Contention operands: index k is offered during cycles 2k and 2k+1.
    logic [VW-1:0] ca0 [3] = '{32'h01010101, 32'h0A0B0C0D, 32'h12345678};
    logic [VW-1:0] cb0 [3] = '{32'h01010101, 32'h10101010, 32'h11111111};
    logic [VW-1:0] ca1 [3] = '{32'h10203040, 32'hF0F0F0F0, 32'h80808080};
    logic [VW-1:0] cb1 [3] = '{32'h01020304, 32'h20202020, 32'h7F7F7F7F};
    logic [VW-1:0] cy  [6] = '{32'h02020202, 32'h11223344, 32'h1A1B1C1D,
                               32'h10101010, 32'h23456789, 32'hFFFFFFFF};
    logic [CW-1:0] co0 [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [CW-1:0] co1 [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [VW-1:0] gy  [9] = '{32'h0, 32'h0, 32'h10101010, 32'h0, 32'h12121212,
                               32'h0, 32'h0, 32'h15151515, 32'h0};

    initial begin
        // Reset: both requesting, nothing may be granted.
        reset = 1'b1;
        drive(1'b1, 32'h11111111, 32'h22222222, 1'b1, 32'h33333333, 32'h44444444);
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_dsp_en", dsp_en, 0);
        tick();
        tick();
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_outst0", outst0, 0);
        chk("rst_outst1", outst1, 0);
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("idle_dsp_en", dsp_en, 1);
        chk("idle_ready0", req0_ready, 0);
        chk("idle_dsp_a", dsp_a, 0);
        tick();

        // Contention: six dual-request cycles, then two drain cycles.
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(1'b1, ca0[i/2], cb0[i/2], 1'b1, ca1[i/2], cb1[i/2]);
            else       drive(1'b0, '0, '0, 1'b0, '0, '0);
            #1;
            chk("cont_ready0", req0_ready, (i < 6) && (i % 2 == 0));
            chk("cont_ready1", req1_ready, (i < 6) && (i % 2 == 1));
            if (i < 6) chk("cont_dsp_a", dsp_a, (i % 2 == 0) ? ca0[i/2] : ca1[i/2]);
            if (i < 6) chk("cont_dsp_b", dsp_b, (i % 2 == 0) ? cb0[i/2] : cb1[i/2]);
            chk("cont_outst0", outst0, co0[i]);
            chk("cont_outst1", outst1, co1[i]);
            if (i >= 2) begin
                chk("cont_rsp0", rsp0_valid, (i % 2 == 0));
                chk("cont_rsp1", rsp1_valid, (i % 2 == 1));
                chk("cont_y", (i % 2 == 0) ? rsp0_y : rsp1_y, cy[i-2]);
            end else begin
                chk("cont_rsp0_early", rsp0_valid, 0);
                chk("cont_rsp1_early", rsp1_valid, 0);
            end
            tick();
        end
        chk("cont_end_outst0", outst0, 0);
        chk("cont_end_outst1", outst1, 0);
        chk("cont_end_rsp", {rsp0_valid, rsp1_valid}, 0);

        // Overflow: lane0 127+1, lane1 -128+-1, lanes 2/3 ordinary.
        drive(1'b1, 32'h1005807F, 32'h2003FF01, 1'b0, '0, '0);
        #1;
        chk("wrap_ready0", req0_ready, 1);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        chk("wrap_rsp0", rsp0_valid, 1);
        chk("wrap_y", rsp0_y, 32'h30087F80);
        tick();

        // Idle gaps: requester 1 valid on cycles 0, 2, 5; junk operands otherwise.
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || i == 2 || i == 5)
                drive(1'b0, '0, '0, 1'b1, 32'h01010101 * i, 32'h10101010);
            else
                drive(1'b0, '0, '0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
            #1;
            chk("gap_ready1", req1_ready, (i == 0 || i == 2 || i == 5));
            chk("gap_rsp1", rsp1_valid, (i == 2 || i == 4 || i == 7));
            chk("gap_rsp0", rsp0_valid, 0);
            if (i == 2 || i == 4 || i == 7) chk("gap_y", rsp1_y, gy[i]);
            tick();
        end

        // Reset mid-flight: req1 then req0 issue, reset lands before either response.
        drive(1'b0, '0, '0, 1'b1, 32'h01000000, 32'h01000000);
        tick();
        drive(1'b1, 32'h00000002, 32'h00000002, 1'b0, '0, '0);
        tick();
        reset = 1'b1;
        drive(1'b1, 32'h5, 32'h5, 1'b1, 32'h7, 32'h7);
        #1;
        chk("mid_rst_rsp0", rsp0_valid, 0);
        chk("mid_rst_rsp1", rsp1_valid, 0);
        chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
        chk("mid_rst_outst", {outst0, outst1}, 0);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("post_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("post_rst_outst", {outst0, outst1}, 0);
        tick();
        drive(1'b1, 32'h00000005, 32'h00000006, 1'b1, 32'h00000009, 32'h00000009);
        #1;
        chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("post_rst_quiet", {rsp0_valid, rsp1_valid}, 0);
        tick();
        chk("post_rst_rsp0", rsp0_valid, 1);
        chk("post_rst_rsp1", rsp1_valid, 0);
        chk("post_rst_y", rsp0_y, 32'h0000000B);
        tick();

        // Fairness: req0 alone for three cycles, then both contend.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1, 32'h1, 1'b0, '0, '0);
            #1;
            chk("fair_solo0", req0_ready, 1);
            tick();
        end
        drive(1'b1, 32'h2, 32'h2, 1'b1, 32'h3, 32'h3);
        #1;
        chk("fair_first1", req1_ready, 1);
        chk("fair_first0", req0_ready, 0);
        tick();
        #1;
        chk("fair_next0", req0_ready, 1);
        chk("fair_next1", req1_ready, 0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        chk("fair_drain_outst", {outst0, outst1}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
